// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/long-latency stalls, flush control,
// and a pending-write scoreboard for multi-cycle mul/div results.
module hazard_scoreboard_unit #(
    parameter  int NUM_REGS    = 32,
    parameter  int MAX_LONG    = 2,
    parameter  int STALL_CNT_W = 16,
    localparam int ADDR_W      = $clog2(NUM_REGS),
    localparam int CNT_W       = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_br_sel_e,
    input  logic                   i_taken_flush,
    input  logic                   i_rd_wren_e,
    input  logic                   i_rd_wren_m,
    input  logic                   i_rd_wren_w,
    input  logic [1:0]             i_wb_sel_e,
    input  logic [ADDR_W-1:0]      i_rs1_d,
    input  logic [ADDR_W-1:0]      i_rs2_d,
    input  logic [ADDR_W-1:0]      i_rd_d,
    input  logic [ADDR_W-1:0]      i_rs1_e,
    input  logic [ADDR_W-1:0]      i_rs2_e,
    input  logic [ADDR_W-1:0]      i_rd_e,
    input  logic [ADDR_W-1:0]      i_rd_m,
    input  logic [ADDR_W-1:0]      i_rd_w,
    input  logic                   i_long_op_d,
    input  logic                   i_long_issue_e,
    input  logic                   i_long_done,
    input  logic [ADDR_W-1:0]      i_long_rd,
    input  logic                   i_cnt_clr,
    output logic                   o_stall_f,
    output logic                   o_stall_d,
    output logic                   o_flush_d,
    output logic                   o_flush_e,
    output logic                   o_forward_a_d,
    output logic                   o_forward_b_d,
    output logic [1:0]             o_forward_a_e,
    output logic [1:0]             o_forward_b_e,
    output logic [NUM_REGS-1:0]    o_sb_pending,
    output logic [CNT_W-1:0]       o_long_cnt,
    output logic [STALL_CNT_W-1:0] o_stall_cnt,
    output logic                   o_sb_err
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_eff;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [CNT_W-1:0]    long_cnt;
    logic [CNT_W:0]      cnt_with_issue;
    logic                done_ok;
    logic                issue_ok;
    logic                done_bad;
    logic                issue_bad;
    logic                stall_load;
    logic                stall_raw;
    logic                stall_long_e;
    logic                stall_waw;
    logic                stall_struct;
    logic                stall;
    logic                redirect;
    logic                rd_wren_e_unused;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                sb_err;

    function automatic logic [1:0] fwd_e(input logic [ADDR_W-1:0] rs);
        if (i_rd_wren_m && i_rd_m != '0 && i_rd_m == rs)
            return 2'b10;
        else if (i_rd_wren_w && i_rd_w != '0 && i_rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign o_forward_a_e = fwd_e(i_rs1_e);
    assign o_forward_b_e = fwd_e(i_rs2_e);
    assign o_forward_a_d = i_rd_wren_m && i_rs1_d != '0 && i_rs1_d == i_rd_m;
    assign o_forward_b_d = i_rd_wren_m && i_rs2_d != '0 && i_rs2_d == i_rd_m;
    assign rd_wren_e_unused = i_rd_wren_e;

    // Updates that would corrupt the count or the bitmap are flagged and dropped.
    assign done_bad  = i_long_done && (long_cnt == '0 || (i_long_rd != '0 && !pending[i_long_rd]));
    assign done_ok   = i_long_done && !done_bad;
    assign issue_bad = i_long_issue_e && long_cnt == CNT_W'(MAX_LONG);
    assign issue_ok  = i_long_issue_e && !issue_bad;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_ok && i_rd_e != '0)
            set_mask[i_rd_e] = 1'b1;
        if (done_ok)
            clr_mask[i_long_rd] = 1'b1;
    end

    // A result written back this cycle no longer blocks its readers.
    assign pending_eff = pending & ~clr_mask;

    assign cnt_with_issue = {1'b0, long_cnt} + (CNT_W+1)'(i_long_issue_e);

    assign stall_load   = i_wb_sel_e[0] && i_rd_e != '0 && (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
    assign stall_raw    = (i_rs1_d != '0 && pending_eff[i_rs1_d]) ||
                          (i_rs2_d != '0 && pending_eff[i_rs2_d]);
    assign stall_long_e = i_long_issue_e && i_rd_e != '0 &&
                          (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d || i_rd_e == i_rd_d);
    assign stall_waw    = i_rd_d != '0 && pending_eff[i_rd_d];
    assign stall_struct = i_long_op_d && cnt_with_issue >= (CNT_W+1)'(MAX_LONG);
    assign stall        = stall_load | stall_raw | stall_long_e | stall_waw | stall_struct;

    assign redirect  = i_br_sel_e | i_taken_flush;
    assign o_stall_f = stall;
    assign o_stall_d = stall;
    assign o_flush_d = redirect;
    assign o_flush_e = stall | redirect;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending   <= '0;
            long_cnt  <= '0;
            stall_cnt <= '0;
            sb_err    <= 1'b0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
            if (issue_ok && !done_ok)
                long_cnt <= long_cnt + 1'b1;
            else if (done_ok && !issue_ok)
                long_cnt <= long_cnt - 1'b1;
            if (i_cnt_clr)
                stall_cnt <= '0;
            else if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (done_bad || issue_bad)
                sb_err <= 1'b1;
        end
    end

    assign o_sb_pending = pending;
    assign o_long_cnt   = long_cnt;
    assign o_stall_cnt  = stall_cnt;
    assign o_sb_err     = sb_err;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit with immediate-assertion checks.
module tb_hazard_scoreboard_unit;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int SCW      = 8;

    logic clk = 1'b0;
    logic rst;
    logic br_sel_e, taken_flush, rd_wren_e, rd_wren_m, rd_wren_w;
    logic [1:0] wb_sel_e;
    logic [ADDR_W-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd;
    logic long_op_d, long_issue_e, long_done, cnt_clr;
    logic stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [NUM_REGS-1:0] sb_pending;
    logic [3:0] long_cnt;
    logic [SCW-1:0] stall_cnt;
    logic sb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.NUM_REGS(NUM_REGS), .MAX_LONG(2), .STALL_CNT_W(SCW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_br_sel_e(br_sel_e), .i_taken_flush(taken_flush),
        .i_rd_wren_e(rd_wren_e), .i_rd_wren_m(rd_wren_m), .i_rd_wren_w(rd_wren_w),
        .i_wb_sel_e(wb_sel_e),
        .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rd_d(rd_d),
        .i_rs1_e(rs1_e), .i_rs2_e(rs2_e), .i_rd_e(rd_e),
        .i_rd_m(rd_m), .i_rd_w(rd_w),
        .i_long_op_d(long_op_d), .i_long_issue_e(long_issue_e),
        .i_long_done(long_done), .i_long_rd(long_rd), .i_cnt_clr(cnt_clr),
        .o_stall_f(stall_f), .o_stall_d(stall_d), .o_flush_d(flush_d), .o_flush_e(flush_e),
        .o_forward_a_d(fwd_a_d), .o_forward_b_d(fwd_b_d),
        .o_forward_a_e(fwd_a_e), .o_forward_b_e(fwd_b_e),
        .o_sb_pending(sb_pending), .o_long_cnt(long_cnt),
        .o_stall_cnt(stall_cnt), .o_sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        br_sel_e = 0; taken_flush = 0; rd_wren_e = 0; rd_wren_m = 0; rd_wren_w = 0;
        wb_sel_e = 2'b00; rs1_d = 0; rs2_d = 0; rd_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m = 0; rd_w = 0; long_op_d = 0; long_issue_e = 0;
        long_done = 0; long_rd = 0; cnt_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        chk("rst_pending", sb_pending, 0);
        chk("rst_long_cnt", long_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_err", sb_err, 0);
        chk("rst_stall", stall_f, 0);
        rst = 1'b0;

        // load-use
        wb_sel_e = 2'b01; rd_e = 5; rs1_d = 5; #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_e", flush_e, 1);
        chk("lu_flush_d", flush_d, 0);
        rd_e = 0; rs1_d = 0; #1;
        chk("lu_rd0_stall", stall_f, 0);
        idle();

        // forwarding
        rd_wren_m = 1; rd_m = 3; rd_wren_w = 1; rd_w = 3; rs1_e = 3; rs2_e = 4; #1;
        chk("fwd_a_e_m", fwd_a_e, 2'b10);
        chk("fwd_b_e_rf", fwd_b_e, 2'b00);
        rd_m = 0; #1;
        chk("fwd_a_e_w", fwd_a_e, 2'b01);
        rd_m = 3; rs1_d = 3; rs2_d = 0; #1;
        chk("fwd_a_d", fwd_a_d, 1);
        chk("fwd_b_d_zero", fwd_b_d, 0);
        rd_wren_w = 0; rd_wren_m = 0; #1;
        chk("fwd_a_e_none", fwd_a_e, 2'b00);
        idle();

        // long-op RAW with same-cycle writeback bypass
        long_issue_e = 1; rd_e = 7; #1;
        chk("issue7_nostall", stall_f, 0);
        tick();
        chk("issue7_pending", sb_pending, 32'h0000_0080);
        chk("issue7_cnt", long_cnt, 1);
        idle(); rs2_d = 7; #1;
        chk("raw7_stall", stall_f, 1);
        tick();
        chk("raw7_stall_hold", stall_f, 1);
        long_done = 1; long_rd = 7; #1;
        chk("raw7_bypass", stall_f, 0);
        tick();
        chk("done7_pending", sb_pending, 0);
        chk("done7_cnt", long_cnt, 0);
        chk("stall_cnt_one", stall_cnt, 1);
        idle();

        // structural limit, WAW and long-E
        long_issue_e = 1; rd_e = 8; tick();
        rd_e = 9; long_op_d = 1; #1;
        chk("struct_cnt1_issue", stall_f, 1);
        tick();
        chk("two_issued_cnt", long_cnt, 2);
        chk("two_issued_pend", sb_pending, 32'h0000_0300);
        idle(); long_op_d = 1; #1;
        chk("struct_stall", stall_f, 1);
        long_done = 1; long_rd = 8; #1;
        chk("struct_done_no_credit", stall_f, 1);
        tick();
        chk("one_done_cnt", long_cnt, 1);
        long_done = 0; #1;
        chk("struct_released", stall_f, 0);
        long_op_d = 0; rd_d = 9; #1;
        chk("waw_stall", stall_f, 1);
        long_done = 1; long_rd = 9; #1;
        chk("waw_bypass", stall_f, 0);
        tick();
        chk("all_done_cnt", long_cnt, 0);
        idle();
        long_issue_e = 1; rd_e = 10; rd_d = 10; #1;
        chk("long_e_stall", stall_f, 1);
        long_issue_e = 0; rd_d = 0; br_sel_e = 1; #1;
        chk("br_flush_d", flush_d, 1);
        chk("br_flush_e", flush_e, 1);
        chk("br_no_stall", stall_f, 0);
        idle();

        // protocol error
        long_done = 1; long_rd = 0; tick();
        chk("err_set", sb_err, 1);
        chk("err_cnt0", long_cnt, 0);
        idle(); tick();
        chk("err_sticky", sb_err, 1);

        // asynchronous reset mid-run
        long_issue_e = 1; rd_e = 12; tick();
        idle();
        chk("pre_rst_pend", sb_pending, 32'h0000_1000);
        rst = 1'b1; #1;
        chk("arst_pending", sb_pending, 0);
        chk("arst_cnt", long_cnt, 0);
        chk("arst_err", sb_err, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        #1 rst = 1'b0;

        // saturating stall counter
        wb_sel_e = 2'b01; rd_e = 5; rs1_d = 5;
        repeat ((1 << SCW) + 3) tick();
        chk("stall_cnt_sat", stall_cnt, {SCW{1'b1}});
        cnt_clr = 1; tick();
        chk("stall_cnt_clr", stall_cnt, 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
